efpga_cfg_ctrl: RTL and testbench
=================================

# efpga_cfg_ctrl

Runtime configuration controller for the eFPGA fabric. It accepts bitstream words from a CPU or DMA source over a valid/ready stream and serializes them, LSB first, into the fabric configuration chain (`prog`, qualified by `prog_en`). It sequences the `prog_rst` and `fpga_rst` phases around the load and reports busy, done and error status. This replaces fixed ROM-based boot with software-driven reconfiguration.

## Interface
- `DATA_W`, 32: width of the bitstream input word.
- `LEN_W`, 14: width of the bitstream length in bits.
- `SETTLE_CYCLES`, 16: number of cycles held in SETTLE before loading starts.
- `TIMEOUT`, 1024: number of consecutive starved cycles in LOAD before the controller enters ERROR.
- `clk` input 1: single clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: one-cycle pulse that begins a configuration.
- `abort` input 1: one-cycle pulse that cancels the current configuration.
- `bit_len` input LEN_W: bitstream length in bits, latched on an accepted `start`.
- `s_valid` input 1: input word valid.
- `s_ready` output 1: controller can accept a word.
- `s_data` input DATA_W: bitstream word; bit 0 is shifted out first.
- `prog` output 1: configuration chain data bit.
- `prog_en` output 1: `prog` is valid this cycle; acts as the chain shift enable.
- `prog_rst` output 1: configuration chain reset, active-high.
- `fpga_rst` output 1: fabric reset, active-high.
- `busy` output 1: controller is in SETTLE or LOAD.
- `done` output 1: configuration completed successfully.
- `error` output 1: configuration failed (zero length or timeout).

## Operation
- **Reset values:** state IDLE, `prog`=0, `prog_en`=0, `s_ready`=0, `prog_rst`=1, `fpga_rst`=1, `busy`=0, `done`=0, `error`=0. All outputs are registered.
- **IDLE / DONE / ERROR:** `start` latches `bit_len` into a remaining-bit counter.
  - If `bit_len`==0, go to ERROR.
  - Otherwise clear `done` and `error`, set `prog_rst`=1 and `fpga_rst`=1, and go to SETTLE.
- **`start` while busy:** ignored.
- **SETTLE:** count exactly SETTLE_CYCLES cycles, then go to LOAD.
- **LOAD:** `prog_rst`=0 and `fpga_rst`=1.
  - A 32-bit shift register holds a bit-in-word count `wbits`.
  - `s_ready`=1 when `wbits`<=1 and the remaining bits exceed the bits already buffered.
  - On a handshake, load the shift register and set `wbits`=DATA_W.
  - Each cycle with `wbits`>0: drive `prog`=shift[0] and `prog_en`=1, shift right, and decrement both `wbits` and the remaining count.
  - Loading a word in the same cycle that the last buffered bit is emitted gives gapless streaming.
- **Final partial word:** when the remaining count reaches 0, the leftover `wbits` are discarded and `s_ready` stays 0.
- **LOAD → DONE:** on the cycle after the final `prog_en`, drop `fpga_rst` to 0, set `done`=1 and `busy`=0.
- **DONE:** hold until the next `start` or `abort`.
- **Starvation:** a starve counter increments on each LOAD cycle with `wbits`==0 and no handshake, and clears on every handshake.
  - When it reaches TIMEOUT, go to ERROR: `error`=1, `prog_rst`=1, `fpga_rst`=1, `busy`=0, `s_ready`=0.
- **`abort`** (any state): go to IDLE with `prog_rst`=1, `fpga_rst`=1, `prog_en`=0, `s_ready`=0, `busy`=0, `done`=0, `error`=0.
  - `abort` wins over a simultaneous `start`.
  - A word presented in the abort cycle is not accepted.
- **`rst_n` assertion mid-load:** all outputs return to their reset values immediately (asynchronous).

## Timing
- Cycle 0 is the cycle in which `start` is sampled.
- `busy`=1 from cycle 1.
- SETTLE occupies cycles 1..S, where S = SETTLE_CYCLES.
- `s_ready`=1 from cycle S+1.
- With `s_valid` held high, the first word is accepted in cycle S+1 and `prog_en` is high for cycles S+2 .. S+1+L, where L = `bit_len`.
- `done`=1 and `fpga_rst`=0 in cycle S+2+L.
- Each starved cycle delays `done` by one cycle.
- `prog_en` is never high in SETTLE, DONE, ERROR or IDLE.

## Test plan
- **Reset values:** release `rst_n` with inputs idle → all outputs at reset values; `s_ready`=0 for 100 cycles.
- **Gapless two-word load:** `bit_len`=64, SETTLE_CYCLES=16, `s_valid` always high, words 0xA5A5_0001 and 0xFFFF_0000.
  - Required: exactly 2 handshakes.
  - Required: `prog_en` high for cycles 18..81; `prog` serial sequence equals the words LSB first.
  - Required: `done`=1 and `fpga_rst`=0 at cycle 82.
- **Partial word with stall:** `bit_len`=40, second word delayed 5 cycles → 40 `prog_en` pulses, with a 5-cycle gap after bit 32; upper 24 bits of the second word are not emitted; `done` 5 cycles later than the gapless case.
- **Timeout:** `bit_len`=64, only one word supplied, TIMEOUT=1024 → `error`=1 and `fpga_rst`=1 exactly 1024 starved cycles after bit 32; a new `start` clears `error`.
- **Abort mid-load:** `abort` at bit 10 → next cycle IDLE, `prog_en`=0, `prog_rst`=1, `busy`=0, `done`=0. A `start` in the same cycle as `abort` is ignored.
- **Zero length and busy start:** `start` with `bit_len`=0 → ERROR next cycle with no `prog_en`. A `start` during LOAD → ignored; the original length completes.

Source files
------------

// File: rtl/efpga_cfg_ctrl.sv
// Runtime eFPGA configuration controller: streams bitstream words LSB-first into the
// fabric configuration chain and sequences the chain/fabric resets around the load.
module efpga_cfg_ctrl #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned LEN_W         = 14,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  bit_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              prog,
  output logic              prog_en,
  output logic              prog_rst,
  output logic              fpga_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned WBITS_W  = $clog2(DATA_W + 1);
  localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned STARVE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StSettle, StLoad, StDone, StError} state_e;

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [WBITS_W-1:0]  wbits_q, wbits_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic prog_q, prog_d, prog_en_q, prog_en_d, s_ready_q, s_ready_d;
  logic prog_rst_q, prog_rst_d, fpga_rst_q, fpga_rst_d;
  logic busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic hs;

  assign hs = s_ready_q & s_valid;

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    rem_d      = rem_q;
    shift_d    = shift_q;
    wbits_d    = wbits_q;
    starve_d   = starve_q;
    prog_d     = 1'b0;
    prog_en_d  = 1'b0;
    s_ready_d  = 1'b0;
    prog_rst_d = prog_rst_q;
    fpga_rst_d = fpga_rst_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;

    if (abort) begin
      state_d    = StIdle;
      prog_rst_d = 1'b1;
      fpga_rst_d = 1'b1;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      error_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone, StError: begin
          if (start) begin
            rem_d      = bit_len;
            wbits_d    = '0;
            starve_d   = '0;
            settle_d   = '0;
            done_d     = 1'b0;
            prog_rst_d = 1'b1;
            fpga_rst_d = 1'b1;
            if (bit_len == '0) begin
              state_d = StError;
              error_d = 1'b1;
            end else begin
              state_d = StSettle;
              error_d = 1'b0;
              busy_d  = 1'b1;
            end
          end
        end
        StSettle: begin
          if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
            state_d    = StLoad;
            prog_rst_d = 1'b0;
            s_ready_d  = (rem_q != '0);
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        StLoad: begin
          if (rem_q == '0) begin
            // Any bits still buffered belong past the requested length and are dropped.
            state_d    = StDone;
            fpga_rst_d = 1'b0;
            done_d     = 1'b1;
            busy_d     = 1'b0;
          end else begin
            if (wbits_q != '0) begin
              prog_d    = shift_q[0];
              prog_en_d = 1'b1;
              shift_d   = shift_q >> 1;
              wbits_d   = wbits_q - 1'b1;
              rem_d     = rem_q - 1'b1;
              if (hs) begin
                shift_d = s_data;
                wbits_d = WBITS_W'(DATA_W);
              end
            end else if (hs) begin
              // Empty buffer: emit bit 0 of the incoming word straight away.
              prog_d    = s_data[0];
              prog_en_d = 1'b1;
              shift_d   = s_data >> 1;
              wbits_d   = WBITS_W'(DATA_W - 1);
              rem_d     = rem_q - 1'b1;
            end

            if (hs) begin
              starve_d = '0;
            end else if (wbits_q == '0) begin
              starve_d = starve_q + 1'b1;
            end

            if (!hs && (wbits_q == '0) && (starve_q == STARVE_W'(TIMEOUT - 1))) begin
              state_d    = StError;
              error_d    = 1'b1;
              prog_rst_d = 1'b1;
              fpga_rst_d = 1'b1;
              busy_d     = 1'b0;
            end else begin
              s_ready_d = (wbits_d <= WBITS_W'(1)) && (rem_d > LEN_W'(wbits_d));
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      settle_q   <= '0;
      rem_q      <= '0;
      shift_q    <= '0;
      wbits_q    <= '0;
      starve_q   <= '0;
      prog_q     <= 1'b0;
      prog_en_q  <= 1'b0;
      s_ready_q  <= 1'b0;
      prog_rst_q <= 1'b1;
      fpga_rst_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      rem_q      <= rem_d;
      shift_q    <= shift_d;
      wbits_q    <= wbits_d;
      starve_q   <= starve_d;
      prog_q     <= prog_d;
      prog_en_q  <= prog_en_d;
      s_ready_q  <= s_ready_d;
      prog_rst_q <= prog_rst_d;
      fpga_rst_q <= fpga_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign prog     = prog_q;
  assign prog_en  = prog_en_q;
  assign s_ready  = s_ready_q;
  assign prog_rst = prog_rst_q;
  assign fpga_rst = fpga_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_efpga_cfg_ctrl.sv
// Bench for efpga_cfg_ctrl: expected chain bits are queued as words are offered and
// popped as prog_en pulses appear; per-scenario tasks check timing against cycle numbers.
module tb_efpga_cfg_ctrl;

  localparam int S  = 16;
  localparam int TO = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [13:0] bit_len = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        prog, prog_en, prog_rst, fpga_rst, busy, done, error;
  logic [7:0]  outs;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   hs_count = 0;
  int   pe_rel[$];
  logic exp_q[$];

  assign outs = {prog, prog_en, s_ready, prog_rst, fpga_rst, busy, done, error};

  efpga_cfg_ctrl #(
    .DATA_W(32), .LEN_W(14), .SETTLE_CYCLES(S), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .bit_len(bit_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .prog(prog),
    .prog_en(prog_en), .prog_rst(prog_rst), .fpga_rst(fpga_rst), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every chain shift must match the next queued bit.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_valid && s_ready) hs_count++;
      if (prog_en) begin
        pe_rel.push_back(cyc - start_cyc);
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_unexpected_shift: cycle %0d prog=%b, no bit expected",
                   cyc - start_cyc, prog);
        end else begin
          logic e;
          e = exp_q.pop_front();
          if (prog !== e) begin
            miscompares++;
            $display("FAIL sb_prog_bit: cycle %0d got %b want %b", cyc - start_cyc, prog, e);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic to_cycle(input int k);
    do @(negedge clk); while (cyc < start_cyc + k);
  endtask

  task automatic do_start(input int len);
    @(posedge clk); #1;
    start = 1'b1;
    bit_len = 14'(len);
    start_cyc = cyc;
    hs_count = 0;
    pe_rel.delete();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data = w;
    for (int i = 0; i < nbits; i++) exp_q.push_back(w[i]);
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL send_word_accept: word %h not accepted, got timeout want handshake", w);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (outs !== 8'b0001_1000) begin
      miscompares++;
      $display("FAIL reset_outs: got %b want %b", outs, 8'b0001_1000);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      vectors++;
      if (outs !== 8'b0001_1000) begin
        miscompares++;
        $display("FAIL reset_idle_%0d: got %b want %b", i, outs, 8'b0001_1000);
      end
    end
  endtask

  task automatic test_gapless();
    do_start(64);
    send_word(32'hA5A5_0001, 32);
    s_valid = 1'b1;
    send_word(32'hFFFF_0000, 32);
    to_cycle(S + 65);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL gapless_done_early: got %b want 0", done);
    end
    to_cycle(S + 66);
    vectors++;
    if (outs !== 8'b0000_0010) begin
      miscompares++;
      $display("FAIL gapless_done: got %b want %b", outs, 8'b0000_0010);
    end
    vectors++;
    if (hs_count !== 2) begin
      miscompares++;
      $display("FAIL gapless_handshakes: got %0d want 2", hs_count);
    end
    vectors++;
    if (pe_rel.size() != 64 || pe_rel[0] != S + 2 || pe_rel[pe_rel.size()-1] != S + 65) begin
      miscompares++;
      $display("FAIL gapless_prog_en_window: got %0d pulses want 64 over cycles %0d..%0d",
               pe_rel.size(), S + 2, S + 65);
    end
  endtask

  task automatic test_partial_stall();
    do_start(40);
    send_word(32'h1234_5678, 32);
    to_cycle(S + 37);
    @(posedge clk); #1;
    send_word(32'hDEAD_BEC3, 8);
    to_cycle(S + 46);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_done_early: got %b want 0", done);
    end
    to_cycle(S + 47);
    vectors++;
    if (outs !== 8'b0000_0010) begin
      miscompares++;
      $display("FAIL stall_done: got %b want %b", outs, 8'b0000_0010);
    end
    vectors++;
    if (pe_rel.size() != 40) begin
      miscompares++;
      $display("FAIL stall_pulse_count: got %0d want 40", pe_rel.size());
    end else begin
      vectors++;
      if (pe_rel[31] != S + 33 || pe_rel[32] != S + 39 || pe_rel[39] != S + 46) begin
        miscompares++;
        $display("FAIL stall_gap: got bits31/32/39 at %0d/%0d/%0d want %0d/%0d/%0d",
                 pe_rel[31], pe_rel[32], pe_rel[39], S + 33, S + 39, S + 46);
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stall_leftover: got %0d unshifted bits want 0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    do_start(64);
    send_word(32'hCAFE_F00D, 32);
    to_cycle(S + TO + 32);
    vectors++;
    if (error !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_early: got error=%b want 0", error);
    end
    to_cycle(S + TO + 33);
    vectors++;
    if (outs !== 8'b0001_1001) begin
      miscompares++;
      $display("FAIL timeout_error: got %b want %b", outs, 8'b0001_1001);
    end
    vectors++;
    if (pe_rel.size() != 32) begin
      miscompares++;
      $display("FAIL timeout_pulses: got %0d want 32", pe_rel.size());
    end
    exp_q.delete();
    do_start(32);
    to_cycle(1);
    vectors++;
    if (outs !== 8'b0001_1100) begin
      miscompares++;
      $display("FAIL timeout_restart: got %b want %b", outs, 8'b0001_1100);
    end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  task automatic test_abort();
    do_start(64);
    send_word(32'h0F0F_3C3C, 32);
    to_cycle(S + 11);
    @(posedge clk); #1;
    abort = 1'b1;
    start = 1'b1;
    bit_len = 14'd5;
    @(negedge clk);
    vectors++;
    if (prog_en !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_bit10_active: got prog_en=%b want 1", prog_en);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (outs !== 8'b0001_1000) begin
      miscompares++;
      $display("FAIL abort_idle: got %b want %b", outs, 8'b0001_1000);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || pe_rel.size() != 11) begin
      miscompares++;
      $display("FAIL abort_start_ignored: got busy=%b pulses=%0d want busy=0 pulses=11",
               busy, pe_rel.size());
    end
    exp_q.delete();
  endtask

  task automatic test_zero_and_busy_start();
    do_start(0);
    to_cycle(1);
    vectors++;
    if (outs !== 8'b0001_1001) begin
      miscompares++;
      $display("FAIL zero_len_error: got %b want %b", outs, 8'b0001_1001);
    end
    to_cycle(4);
    vectors++;
    if (pe_rel.size() != 0) begin
      miscompares++;
      $display("FAIL zero_len_shifts: got %0d want 0", pe_rel.size());
    end
    do_start(32);
    send_word(32'h8000_0001, 32);
    to_cycle(S + 9);
    @(posedge clk); #1;
    start = 1'b1;
    bit_len = 14'd8;
    @(posedge clk); #1;
    start = 1'b0;
    to_cycle(S + 33);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_start_early: got done=%b busy=%b want 0/1", done, busy);
    end
    to_cycle(S + 34);
    vectors++;
    if (outs !== 8'b0000_0010 || pe_rel.size() != 32) begin
      miscompares++;
      $display("FAIL busy_start_ignored: got %b pulses=%0d want %b pulses=32",
               outs, pe_rel.size(), 8'b0000_0010);
    end
  endtask

  task automatic test_async_reset();
    do_start(32);
    send_word(32'h5555_AAAA, 32);
    to_cycle(S + 10);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (outs !== 8'b0001_1000) begin
      miscompares++;
      $display("FAIL async_reset: got %b want %b", outs, 8'b0001_1000);
    end
    @(negedge clk) rst_n = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    vectors++;
    if (outs !== 8'b0001_1000) begin
      miscompares++;
      $display("FAIL async_reset_after: got %b want %b", outs, 8'b0001_1000);
    end
  endtask

  initial begin
    test_reset();
    test_gapless();
    test_partial_stall();
    test_timeout();
    test_abort();
    test_zero_and_busy_start();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
